// File: rtl/dac_bus_capture.sv
// De-interleaves a dual-channel DAC sample bus into channel A/B pairs,
// converts offset binary to two's complement and supervises link health.
module dac_bus_capture #(
   parameter int DW            = 14,
   parameter int TIMEOUT       = 1024,
   parameter bit OFFSET_BINARY = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   input  logic          daclk_in,
   input  logic          ws_in,
   output logic [DW-1:0] dout_a,
   output logic [DW-1:0] dout_b,
   output logic          dout_valid,
   output logic          seq_err,
   output logic          link_up,
   output logic [15:0]   pair_cnt
);

   localparam int             WDW    = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

   typedef enum logic {WAIT_A, WAIT_B} state_t;

   logic [DW-1:0]  r_din_s1, r_din_s2;
   logic           r_ws_s1, r_ws_s2;
   logic           r_clk_s1, r_clk_s2, r_clk_s3;
   state_t         r_state;
   logic [DW-1:0]  r_a_hold;
   logic [WDW-1:0] r_wd;
   logic [DW-1:0]  r_dout_a, r_dout_b;
   logic           r_dout_valid, r_seq_err, r_link_up;
   logic [15:0]    r_pair_cnt;

   logic           w_edge;
   logic           w_expire;
   logic [DW-1:0]  w_conv;
   logic [WDW-1:0] w_wd_next;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_edge = r_clk_s2 & ~r_clk_s3;
      w_conv = r_din_s2;
      if (OFFSET_BINARY)
         w_conv = {~r_din_s2[DW-1], r_din_s2[DW-2:0]};
      w_wd_next = r_wd;
      if (w_edge)
         w_wd_next = '0;
      else if (r_wd != WD_MAX)
         w_wd_next = r_wd + WDW'(1);
      // An edge landing on the expiry cycle keeps the link alive.
      w_expire = ~w_edge && (w_wd_next == WD_MAX);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_din_s1     <= '0;
         r_din_s2     <= '0;
         r_ws_s1      <= 1'b0;
         r_ws_s2      <= 1'b0;
         r_clk_s1     <= 1'b0;
         r_clk_s2     <= 1'b0;
         r_clk_s3     <= 1'b0;
         r_state      <= WAIT_A;
         r_a_hold     <= '0;
         r_wd         <= '0;
         r_dout_a     <= '0;
         r_dout_b     <= '0;
         r_dout_valid <= 1'b0;
         r_seq_err    <= 1'b0;
         r_link_up    <= 1'b0;
         r_pair_cnt   <= '0;
      end else begin
         r_din_s1     <= din;
         r_din_s2     <= r_din_s1;
         r_ws_s1      <= ws_in;
         r_ws_s2      <= r_ws_s1;
         r_clk_s1     <= daclk_in;
         r_clk_s2     <= r_clk_s1;
         r_clk_s3     <= r_clk_s2;
         r_wd         <= w_wd_next;
         r_dout_valid <= 1'b0;
         r_seq_err    <= 1'b0;

         if (w_edge) begin
            case (r_state)
               WAIT_A: begin
                  if (!r_ws_s2) begin
                     r_a_hold <= w_conv;
                     r_state  <= WAIT_B;
                  end else begin
                     r_seq_err <= 1'b1;
                  end
               end
               WAIT_B: begin
                  if (r_ws_s2) begin
                     r_dout_a     <= r_a_hold;
                     r_dout_b     <= w_conv;
                     r_dout_valid <= 1'b1;
                     r_pair_cnt   <= r_pair_cnt + 16'd1;
                     r_link_up    <= 1'b1;
                     r_state      <= WAIT_A;
                  end else begin
                     // Resynchronise on the newest A sample.
                     r_seq_err <= 1'b1;
                     r_a_hold  <= w_conv;
                  end
               end
               default: r_state <= WAIT_A;
            endcase
         end else if (w_expire) begin
            r_link_up <= 1'b0;
            r_state   <= WAIT_A;
            r_a_hold  <= '0;
         end
      end
   end

   assign dout_a     = r_dout_a;
   assign dout_b     = r_dout_b;
   assign dout_valid = r_dout_valid;
   assign seq_err    = r_seq_err;
   assign link_up    = r_link_up;
   assign pair_cnt   = r_pair_cnt;

endmodule

// File: tb/tb_dac_bus_capture.sv
// Self-checking bench for dac_bus_capture: table vectors, hand-written corner
// sequences and randomized words checked against a transaction-level model.
module tb_dac_bus_capture;

   localparam int DW = 14;
   localparam int T  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] din = '0;
   logic          daclk_in = 1'b0;
   logic          ws_in = 1'b0;

   logic [DW-1:0] dout_a, dout_b, raw_a, raw_b;
   logic          dout_valid, seq_err, link_up, raw_valid, raw_seq, raw_link;
   logic [15:0]   pair_cnt, raw_cnt;

   dac_bus_capture #(.DW(DW), .TIMEOUT(T), .OFFSET_BINARY(1'b1)) dut (
      .clk(clk), .rst(rst), .din(din), .daclk_in(daclk_in), .ws_in(ws_in),
      .dout_a(dout_a), .dout_b(dout_b), .dout_valid(dout_valid),
      .seq_err(seq_err), .link_up(link_up), .pair_cnt(pair_cnt)
   );

   dac_bus_capture #(.DW(DW), .TIMEOUT(T), .OFFSET_BINARY(1'b0)) dut_raw (
      .clk(clk), .rst(rst), .din(din), .daclk_in(daclk_in), .ws_in(ws_in),
      .dout_a(raw_a), .dout_b(raw_b), .dout_valid(raw_valid),
      .seq_err(raw_seq), .link_up(raw_link), .pair_cnt(raw_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic          ws;
      logic [DW-1:0] d;
      logic          exp_valid;
      logic          exp_seq;
      logic [DW-1:0] exp_a;
      logic [DW-1:0] exp_b;
      logic [15:0]   exp_cnt;
      logic          exp_link;
   } vec_t;

   typedef struct {
      logic          valid;
      logic          seq;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [15:0]   cnt;
      logic          link;
   } obs_t;

   // Transaction-level reference: pending raw A samples, last pair, link, count.
   logic [DW-1:0] m_aq[$];
   logic [DW-1:0] m_a = '0, m_b = '0, m_raw_a = '0, m_raw_b = '0;
   logic          m_link = 1'b0;
   logic [15:0]   m_cnt = '0;
   int            m_last_rise = -1;

   function automatic logic [DW-1:0] to_twos(input logic [DW-1:0] d);
      int v;
      v = int'(d) - (1 << (DW - 1));
      return v[DW-1:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      m_aq.delete();
      m_a = '0; m_b = '0; m_raw_a = '0; m_raw_b = '0;
      m_link = 1'b0;
      m_cnt = '0;
      m_last_rise = -1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      tick(n);
      rst = 1'b0;
      model_reset();
   endtask

   // Drive one word: setup for lo cycles, daclk high for hi cycles (hi >= 4).
   task automatic send_word(input logic ws, input logic [DW-1:0] d,
                            input int lo, input int hi, output obs_t o);
      logic exp_v, exp_s;
      int   rise;
      din   = d;
      ws_in = ws;
      tick(lo);
      daclk_in = 1'b1;
      rise = cyc;

      if (m_last_rise >= 0 && rise - m_last_rise > T) begin
         m_link = 1'b0;
         m_aq.delete();
      end
      m_last_rise = rise;
      exp_v = 1'b0;
      exp_s = 1'b0;
      if (ws == 1'b0) begin
         if (m_aq.size() != 0) exp_s = 1'b1;
         m_aq.delete();
         m_aq.push_back(d);
      end else if (m_aq.size() == 0) begin
         exp_s = 1'b1;
      end else begin
         m_raw_a = m_aq.pop_front();
         m_raw_b = d;
         m_a = to_twos(m_raw_a);
         m_b = to_twos(m_raw_b);
         m_cnt++;
         m_link = 1'b1;
         exp_v = 1'b1;
      end

      tick(3);
      o.valid = dout_valid; o.seq = seq_err; o.a = dout_a; o.b = dout_b;
      o.cnt = pair_cnt; o.link = link_up;
      check("valid", 32'(dout_valid), 32'(exp_v));
      check("seq_err", 32'(seq_err), 32'(exp_s));
      check("dout_a", 32'(dout_a), 32'(m_a));
      check("dout_b", 32'(dout_b), 32'(m_b));
      check("pair_cnt", 32'(pair_cnt), 32'(m_cnt));
      check("link_up", 32'(link_up), 32'(m_link));
      check("raw_valid", 32'(raw_valid), 32'(exp_v));
      if (exp_v) begin
         check("raw_a", 32'(raw_a), 32'(m_raw_a));
         check("raw_b", 32'(raw_b), 32'(m_raw_b));
      end
      tick(1);
      check("valid_width", 32'(dout_valid), 32'd0);
      check("seq_width", 32'(seq_err), 32'd0);
      tick(hi - 4);
      daclk_in = 1'b0;
   endtask

   vec_t  vecs[12];
   obs_t  o;
   logic  r_ws;
   int    a_rise;

   initial begin
      vecs[0]  = '{1'b0, 14'h2000, 1'b0, 1'b0, 14'h0000, 14'h0000, 16'd0, 1'b0};
      vecs[1]  = '{1'b1, 14'h3FFF, 1'b1, 1'b0, 14'h0000, 14'h1FFF, 16'd1, 1'b1};
      vecs[2]  = '{1'b0, 14'h2000, 1'b0, 1'b0, 14'h0000, 14'h1FFF, 16'd1, 1'b1};
      vecs[3]  = '{1'b1, 14'h3FFF, 1'b1, 1'b0, 14'h0000, 14'h1FFF, 16'd2, 1'b1};
      vecs[4]  = '{1'b0, 14'h2000, 1'b0, 1'b0, 14'h0000, 14'h1FFF, 16'd2, 1'b1};
      vecs[5]  = '{1'b1, 14'h3FFF, 1'b1, 1'b0, 14'h0000, 14'h1FFF, 16'd3, 1'b1};
      vecs[6]  = '{1'b0, 14'h2000, 1'b0, 1'b0, 14'h0000, 14'h1FFF, 16'd3, 1'b1};
      vecs[7]  = '{1'b1, 14'h3FFF, 1'b1, 1'b0, 14'h0000, 14'h1FFF, 16'd4, 1'b1};
      vecs[8]  = '{1'b1, 14'h0AAA, 1'b0, 1'b1, 14'h0000, 14'h1FFF, 16'd4, 1'b1};
      vecs[9]  = '{1'b0, 14'h0111, 1'b0, 1'b0, 14'h0000, 14'h1FFF, 16'd4, 1'b1};
      vecs[10] = '{1'b0, 14'h0222, 1'b0, 1'b1, 14'h0000, 14'h1FFF, 16'd4, 1'b1};
      vecs[11] = '{1'b1, 14'h0333, 1'b1, 1'b0, 14'h2222, 14'h2333, 16'd5, 1'b1};

      do_reset(3);
      check("rst_dout_a", 32'(dout_a), 32'd0);
      check("rst_dout_b", 32'(dout_b), 32'd0);
      check("rst_valid", 32'(dout_valid), 32'd0);
      check("rst_seq", 32'(seq_err), 32'd0);
      check("rst_link", 32'(link_up), 32'd0);
      check("rst_cnt", 32'(pair_cnt), 32'd0);

      // Normal pairs and ordering faults at an 8-cycle daclk period.
      for (int i = 0; i < 12; i++) begin
         send_word(vecs[i].ws, vecs[i].d, 4, 4, o);
         check($sformatf("tbl%0d_valid", i), 32'(o.valid), 32'(vecs[i].exp_valid));
         check($sformatf("tbl%0d_seq", i), 32'(o.seq), 32'(vecs[i].exp_seq));
         check($sformatf("tbl%0d_a", i), 32'(o.a), 32'(vecs[i].exp_a));
         check($sformatf("tbl%0d_b", i), 32'(o.b), 32'(vecs[i].exp_b));
         check($sformatf("tbl%0d_cnt", i), 32'(o.cnt), 32'(vecs[i].exp_cnt));
         check($sformatf("tbl%0d_link", i), 32'(o.link), 32'(vecs[i].exp_link));
      end

      // Conversion bypass on the raw instance.
      send_word(1'b0, 14'h0001, 4, 4, o);
      send_word(1'b1, 14'h2ABC, 4, 4, o);
      check("bypass_a", 32'(raw_a), 32'h0001);
      check("bypass_b", 32'(raw_b), 32'h2ABC);
      check("conv_a", 32'(dout_a), 32'h2001);
      check("conv_b", 32'(dout_b), 32'h0ABC);

      // Watchdog: link falls TIMEOUT cycles after the A edge's update.
      send_word(1'b0, 14'h1234, 4, 4, o);
      a_rise = m_last_rise;
      while (cyc < a_rise + 3 + T - 1) tick(1);
      check("wd_link_before", 32'(link_up), 32'd1);
      tick(1);
      check("wd_link_after", 32'(link_up), 32'd0);
      send_word(1'b1, 14'h0555, 4, 4, o);
      check("wd_orphan_seq", 32'(o.seq), 32'd1);
      check("wd_orphan_valid", 32'(o.valid), 32'd0);
      send_word(1'b0, 14'h0100, 4, 4, o);
      send_word(1'b1, 14'h0200, 4, 4, o);
      check("wd_relink", 32'(o.link), 32'd1);

      // Edge exactly at expiry wins; one cycle later it does not.
      send_word(1'b0, 14'h0300, 4, 4, o);
      send_word(1'b1, 14'h0400, T - 4, 4, o);
      check("wd_edge_wins", 32'(o.valid), 32'd1);
      send_word(1'b0, 14'h0500, 4, 4, o);
      send_word(1'b1, 14'h0600, T - 3, 4, o);
      check("wd_expired", 32'(o.seq), 32'd1);

      // Counter wrap.
      send_word(1'b0, 14'h0700, 4, 4, o);
      send_word(1'b1, 14'h0800, 4, 4, o);
      force dut.r_pair_cnt = 16'hFFFE;
      tick(1);
      release dut.r_pair_cnt;
      m_cnt = 16'hFFFE;
      check("force_cnt", 32'(pair_cnt), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         send_word(1'b0, 14'(k), 4, 4, o);
         send_word(1'b1, 14'(k + 8), 4, 4, o);
         check($sformatf("wrap%0d", k), 32'(o.cnt), 32'((16'hFFFF + k) & 16'hFFFF));
      end

      // Reset between an A edge and its B edge.
      send_word(1'b0, 14'h0ABC, 4, 4, o);
      tick(1);
      do_reset(1);
      check("mid_rst_a", 32'(dout_a), 32'd0);
      check("mid_rst_b", 32'(dout_b), 32'd0);
      check("mid_rst_cnt", 32'(pair_cnt), 32'd0);
      check("mid_rst_link", 32'(link_up), 32'd0);
      send_word(1'b1, 14'h0DEF, 4, 4, o);
      check("mid_rst_seq", 32'(o.seq), 32'd1);
      check("mid_rst_valid", 32'(o.valid), 32'd0);

      // Randomized words, mostly alternating with occasional ordering faults.
      r_ws = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(4, 0) != 0) r_ws = ~r_ws;
         send_word(r_ws, 14'($urandom), $urandom_range(12, 3), $urandom_range(8, 4), o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
